exec_stage: RTL
===============

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Ports SHALL be: clk  in  1  sole clock; rst  in  1  synchronous active-high reset, sampled on clk rising edge.
REQ-002 in_valid in 1 issue request; in_ready out 1 stage can accept; in_rs1_val/in_rs2_val/in_imm in 32 each operand values; in_rs1/in_rs2 in 5 each source register addresses; in_is_imm in 1 select immediate as operand 2; in_funct3 in 3; in_funct7 in 7; in_rd in 5 destination.
REQ-003 alu_in1/alu_in2 out 32 each; alu_is_imm out 1; alu_funct3 out 3; alu_funct7 out 7; alu_ready out 1 launch strobe; alu_out in 32 result; alu_done in 1 completion (constant 1 for single-cycle ops, one-cycle pulse for divide/remainder).
REQ-004 wb_valid out 1 result available; wb_ready in 1 consumer accepts; wb_rd out 5; wb_data out 32.

Function
REQ-005 States SHALL be DRAIN, IDLE, LAUNCH, WAIT, RESULT; in_ready SHALL be 1 only in IDLE.
REQ-006 Accept occurs on in_valid&in_ready; all in_* fields SHALL be registered, state -> LAUNCH.
REQ-007 Operand 1 SHALL be in_rs1_val; operand 2 SHALL be in_imm when in_is_imm else in_rs2_val (after forwarding, REQ-018).
REQ-008 alu_in1/alu_in2/alu_is_imm/alu_funct3/alu_funct7 SHALL be driven from registers and held stable from LAUNCH until exit from WAIT.
REQ-009 alu_ready SHALL be 1 for exactly the one LAUNCH cycle, 0 otherwise.
REQ-010 In LAUNCH or WAIT, alu_done=1 SHALL capture alu_out into wb_data, rd into wb_rd, state -> RESULT; alu_done=0 in LAUNCH -> WAIT; WAIT holds until alu_done=1.
REQ-011 alu_done SHALL be ignored in DRAIN, IDLE, RESULT.
REQ-012 Latency: accept in cycle N, single-cycle op -> wb_valid=1 in cycle N+2; divide -> wb_valid=1 the cycle after the alu_done pulse.
REQ-013 wb_valid SHALL be 1 only in RESULT; wb_rd/wb_data SHALL be stable while wb_valid=1 and wb_ready=0.
REQ-014 RESULT with wb_ready=1 SHALL -> IDLE; no same-cycle re-accept (one instruction in flight, max one accept per two cycles).
REQ-015 DRAIN SHALL hold a 6-bit counter loaded with 34 and decrement each cycle; at 0 -> IDLE; guarantees any divide left running by reset has finished and its done pulse has passed.

Reset
REQ-016 rst=1 SHALL set state DRAIN, counter 34, in_ready=0, alu_ready=0, wb_valid=0, wb_rd=0, wb_data=0, alu_in1/alu_in2=0, alu_funct3=0, alu_funct7=0, alu_is_imm=0, forwarding entry invalid.
REQ-017 rst during LAUNCH/WAIT/RESULT SHALL discard the in-flight instruction; no wb_valid issued for it.

Configuration
REQ-018 With EXEC_FWD_EN defined: stage SHALL keep a forwarding entry (rd, data, valid) written on every wb handshake with wb_rd!=0; at accept, in_rs1 (and in_rs2 when in_is_imm=0) matching a valid entry SHALL take the entry's data instead of the input value; address 0 never forwarded.
REQ-019 Without EXEC_FWD_EN: no forwarding entry exists; in_rs1/in_rs2 SHALL be ignored; operands come only from in_rs1_val/in_rs2_val/in_imm.

Verification
REQ-020 Reset then in_valid=1 held: in_ready=0 for 34 cycles after rst deasserts, first accept on cycle 35.
REQ-021 ADD rs1=5, rs2=7, funct3=0, funct7=0, wb_ready=1, ALU model returns 12 with done=1 -> alu_ready pulses once at N+1, wb_valid=1, wb_data=12 at N+2.
REQ-022 DIV funct3=4, funct7=1, 100/7, ALU model pulses done 33 cycles after launch with 14 -> WAIT for 33 cycles, operands held, wb_data=14 one cycle after the pulse.
REQ-023 wb_ready=0 for 5 cycles in RESULT -> wb_valid, wb_rd, wb_data unchanged; in_ready=0; next accept only after handshake.
REQ-024 rst asserted mid-WAIT with ALU model still pulsing done later -> no wb_valid for the discarded op; stale done ignored in DRAIN.
REQ-025 EXEC_FWD_EN: write x3=0x55 via wb, then ADD rs1=x3 with in_rs1_val=0 -> alu_in1=0x55; without macro alu_in1=0; rd=0 write never forwarded.

Source files
------------

// File: rtl/exec_stage.sv
// Single-issue execute stage: registers one instruction, launches it on an external ALU,
// waits for completion and holds the result for writeback. Optional forwarding: EXEC_FWD_EN.
module exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic        in_is_imm,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        alu_is_imm,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic        alu_ready,
  input  logic [31:0] alu_out,
  input  logic        alu_done,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);
  typedef enum logic [2:0] {DRAIN, IDLE, LAUNCH, WAIT, RESULT} state_t;

  // Long enough for a divide orphaned by reset to finish and drop its done pulse.
  localparam logic [5:0] DRAIN_CYCLES = 6'd34;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] in1_q, in1_d;
  logic [31:0] in2_q, in2_d;
  logic        is_imm_q, is_imm_d;
  logic [2:0]  f3_q, f3_d;
  logic [6:0]  f7_q, f7_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] src1, src2;

`ifdef EXEC_FWD_EN
  logic        fwd_v_q, fwd_v_d;
  logic [4:0]  fwd_rd_q, fwd_rd_d;
  logic [31:0] fwd_data_q, fwd_data_d;
  logic        hit1, hit2;

  always_comb begin
    hit1 = fwd_v_q && (in_rs1 != 5'd0) && (in_rs1 == fwd_rd_q);
    hit2 = fwd_v_q && !in_is_imm && (in_rs2 != 5'd0) && (in_rs2 == fwd_rd_q);
    src1 = hit1 ? fwd_data_q : in_rs1_val;
    src2 = in_is_imm ? in_imm : (hit2 ? fwd_data_q : in_rs2_val);
    fwd_v_d    = fwd_v_q;
    fwd_rd_d   = fwd_rd_q;
    fwd_data_d = fwd_data_q;
    if (wb_valid && wb_ready && (wb_rd_q != 5'd0)) begin
      fwd_v_d    = 1'b1;
      fwd_rd_d   = wb_rd_q;
      fwd_data_d = wb_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_v_q    <= 1'b0;
      fwd_rd_q   <= 5'd0;
      fwd_data_q <= 32'd0;
    end else begin
      fwd_v_q    <= fwd_v_d;
      fwd_rd_q   <= fwd_rd_d;
      fwd_data_q <= fwd_data_d;
    end
  end
`else
  // Source addresses only matter when forwarding is built in.
  logic unused_src_addr;
  assign unused_src_addr = ^{in_rs1, in_rs2};

  always_comb begin
    src1 = in_rs1_val;
    src2 = in_is_imm ? in_imm : in_rs2_val;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    is_imm_d  = is_imm_q;
    f3_d      = f3_q;
    f7_d      = f7_q;
    rd_d      = rd_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    in_ready  = 1'b0;
    alu_ready = 1'b0;
    wb_valid  = 1'b0;
    case (state_q)
      DRAIN: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q <= 6'd1) begin
          cnt_d   = 6'd0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in1_d    = src1;
          in2_d    = src2;
          is_imm_d = in_is_imm;
          f3_d     = in_funct3;
          f7_d     = in_funct7;
          rd_d     = in_rd;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        alu_ready = 1'b1;
        if (alu_done) begin
          wb_data_d = alu_out;
          wb_rd_d   = rd_q;
          state_d   = RESULT;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (alu_done) begin
          wb_data_d = alu_out;
          wb_rd_d   = rd_q;
          state_d   = RESULT;
        end
      end
      RESULT: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DRAIN;
      cnt_q     <= DRAIN_CYCLES;
      in1_q     <= 32'd0;
      in2_q     <= 32'd0;
      is_imm_q  <= 1'b0;
      f3_q      <= 3'd0;
      f7_q      <= 7'd0;
      rd_q      <= 5'd0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      is_imm_q  <= is_imm_d;
      f3_q      <= f3_d;
      f7_q      <= f7_d;
      rd_q      <= rd_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_is_imm = is_imm_q;
  assign alu_funct3 = f3_q;
  assign alu_funct7 = f7_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
endmodule
